// File: rtl/mp_coeff_loader_if.sv
// AXI4-Stream coefficient channel into the DPD coefficient loader.
// The master drives data/valid/last and the slave returns ready.
interface mp_coeff_loader_if;
    logic [31:0] s_tdata_i;
    logic        s_tvalid_i;
    logic        s_tlast_i;
    logic        s_tready_o;

    modport master (
        output s_tdata_i,
        output s_tvalid_i,
        output s_tlast_i,
        input  s_tready_o
    );

    modport slave (
        input  s_tdata_i,
        input  s_tvalid_i,
        input  s_tlast_i,
        output s_tready_o
    );
endinterface

// File: rtl/mp_coeff_loader.sv
// Streams coefficient words from AXI4-Stream into the LUT coefficient BRAM write port.
// Supports full-table and single-LUT reloads, and flags frames that are too short or too long.
module mp_coeff_loader #(
    parameter int M          = 3,
    parameter int LUT_num    = M + 1,
    parameter int RESOLUTION = 4096,
    parameter int ADDR_W     = $clog2(RESOLUTION) + $clog2(LUT_num) + 2
) (
    input  logic                       AXI_clk_i,
    input  logic                       reset_n_i,
    input  logic                       start_i,
    input  logic                       all_i,
    input  logic [$clog2(LUT_num)-1:0] lut_sel_i,
    input  logic                       abort_i,
    mp_coeff_loader_if.slave           s_axis,
    output logic [31:0]                coeff_o,
    output logic [ADDR_W-1:0]          coeff_addr_o,
    output logic                       coeff_en_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_short_o,
    output logic                       err_long_o
);

    localparam int RES_W = $clog2(RESOLUTION);
    localparam int WA_W  = ADDR_W - 2;
    // One extra bit lets the count reach the full table size without wrapping
    localparam int CNT_W = WA_W + 1;
    localparam logic [CNT_W-1:0] TOTAL_WORDS = CNT_W'(LUT_num * RESOLUTION);
    localparam logic [CNT_W-1:0] LUT_WORDS   = CNT_W'(RESOLUTION);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  target;
    logic [WA_W-1:0]   base;
    logic [WA_W-1:0]   sel_base;
    logic [WA_W-1:0]   word_addr;
    logic              beat;
    logic              last_word;
    logic              bad_sel;
    logic              start_ok;
    logic              wr;
    logic              set_short;
    logic              set_long;

    assign sel_base  = WA_W'(lut_sel_i) << RES_W;
    assign word_addr = base + cnt[WA_W-1:0];
    assign bad_sel   = (int'(lut_sel_i) >= LUT_num);

    always_comb begin
        next_state = state;
        start_ok   = 1'b0;
        wr         = 1'b0;
        set_short  = 1'b0;
        set_long   = 1'b0;
        beat       = s_axis.s_tvalid_i & s_axis.s_tready_o;
        last_word  = (cnt == (target - ONE));
        case (state)
            IDLE: begin
                // busy_o stays high through the done cycle, so it also gates restarts
                if (start_i && !busy_o) begin
                    start_ok = 1'b1;
                    if (!all_i && bad_sel) begin
                        set_short  = 1'b1;
                        next_state = DONE;
                    end else begin
                        next_state = LOAD;
                    end
                end
            end
            LOAD: begin
                if (beat) begin
                    wr = 1'b1;
                    if (last_word) begin
                        if (s_axis.s_tlast_i) begin
                            next_state = DONE;
                        end else begin
                            set_long   = 1'b1;
                            next_state = FLUSH;
                        end
                    end else if (s_axis.s_tlast_i) begin
                        set_short  = 1'b1;
                        next_state = DONE;
                    end
                end
            end
            FLUSH: begin
                if (beat && s_axis.s_tlast_i) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        // Abort overrides everything, including a beat or a start in the same cycle
        if (abort_i) begin
            next_state = IDLE;
            start_ok   = 1'b0;
            wr         = 1'b0;
            set_short  = 1'b0;
            set_long   = 1'b0;
        end
    end

    always_ff @(posedge AXI_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge AXI_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt               <= '0;
            target            <= '0;
            base              <= '0;
            coeff_o           <= '0;
            coeff_addr_o      <= '0;
            coeff_en_o        <= 1'b0;
            busy_o            <= 1'b0;
            done_o            <= 1'b0;
            err_short_o       <= 1'b0;
            err_long_o        <= 1'b0;
            s_axis.s_tready_o <= 1'b0;
        end else begin
            if (start_ok) begin
                cnt         <= '0;
                base        <= all_i ? '0 : sel_base;
                target      <= all_i ? TOTAL_WORDS : LUT_WORDS;
                err_short_o <= set_short;
                err_long_o  <= 1'b0;
            end else begin
                if (set_short) begin
                    err_short_o <= 1'b1;
                end
                if (set_long) begin
                    err_long_o <= 1'b1;
                end
            end
            if (wr) begin
                coeff_o      <= s_axis.s_tdata_i;
                coeff_addr_o <= {word_addr, 2'b00};
                cnt          <= cnt + ONE;
            end
            coeff_en_o        <= wr;
            s_axis.s_tready_o <= (next_state == LOAD) || (next_state == FLUSH);
            // done_o follows the DONE state by one cycle; busy_o covers that cycle too
            done_o            <= (state == DONE) && !abort_i;
            busy_o            <= (next_state != IDLE) || ((state == DONE) && !abort_i);
        end
    end

endmodule

// File: tb/tb_mp_coeff_loader.sv
// Directed bench for mp_coeff_loader with 4 LUTs of 16 entries.
// A negedge monitor checks every BRAM write against a queue of expected writes.
module tb_mp_coeff_loader;

    localparam int LUT_N = 4;
    localparam int RES   = 16;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       all;
    logic [1:0] lut_sel;
    logic       abort;
    logic [31:0] coeff;
    logic [7:0]  coeff_addr;
    logic        coeff_en;
    logic        busy;
    logic        done;
    logic        err_short;
    logic        err_long;

    int vec_count   = 0;
    int miscompares = 0;
    int write_count = 0;
    int done_count  = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] ea;
    logic [31:0] ed;

    mp_coeff_loader_if s_axis();

    mp_coeff_loader #(
        .M(LUT_N - 1),
        .LUT_num(LUT_N),
        .RESOLUTION(RES)
    ) dut (
        .AXI_clk_i(clk),
        .reset_n_i(reset_n),
        .start_i(start),
        .all_i(all),
        .lut_sel_i(lut_sel),
        .abort_i(abort),
        .s_axis(s_axis),
        .coeff_o(coeff),
        .coeff_addr_o(coeff_addr),
        .coeff_en_o(coeff_en),
        .busy_o(busy),
        .done_o(done),
        .err_short_o(err_short),
        .err_long_o(err_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Write monitor: each enable must match the oldest expected write
    always @(negedge clk) begin
        if (reset_n && coeff_en) begin
            write_count++;
            if (exp_addr.size() == 0) begin
                check_output("extra_write", 32'(coeff_addr), 32'hFFFF_FFFF);
            end else begin
                ea = exp_addr.pop_front();
                ed = exp_data.pop_front();
                check_output("wr_addr", 32'(coeff_addr), ea);
                check_output("wr_data", coeff, ed);
            end
        end
        if (reset_n && done) begin
            done_count++;
        end
    end

    task automatic apply_stimulus(input bit all_mode, input logic [1:0] sel);
        start   = 1'b1;
        all     = all_mode;
        lut_sel = sel;
        @(posedge clk); #1;
        start = 1'b0;
        check_output("start_busy", 32'(busy), 32'd1);
        check_output("start_tready", 32'(s_axis.s_tready_o), 32'd1);
    endtask

    task automatic send_frame(input int base_word, input int n_words, input int n_write, input bit gaps,
                              input logic [31:0] data_base, input bit exp_short, input bit exp_long);
        int n      = 0;
        int cycles = 0;
        int wr0    = write_count;
        int dn0    = done_count;
        bit take;
        while (n < n_words) begin
            s_axis.s_tvalid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            s_axis.s_tdata_i  = data_base + 32'(n);
            s_axis.s_tlast_i  = (n == n_words - 1);
            take = s_axis.s_tvalid_i && s_axis.s_tready_o;
            if (take && n < n_write) begin
                exp_addr.push_back(32'((base_word + n) * 4));
                exp_data.push_back(data_base + 32'(n));
            end
            @(posedge clk); #1;
            if (take) n++;
            cycles++;
            if (cycles > 4 * n_words + 50) begin
                check_output("beat_timeout", 32'(cycles), 32'd0);
                break;
            end
        end
        s_axis.s_tvalid_i = 1'b0;
        s_axis.s_tlast_i  = 1'b0;
        check_output("end_en", 32'(coeff_en), 32'(n_write == n_words));
        check_output("end_done_early", 32'(done), 32'd0);
        check_output("end_busy", 32'(busy), 32'd1);
        check_output("err_short", 32'(err_short), 32'(exp_short));
        check_output("err_long", 32'(err_long), 32'(exp_long));
        @(posedge clk); #1;
        check_output("done_pulse", 32'(done), 32'd1);
        check_output("done_tready", 32'(s_axis.s_tready_o), 32'd0);
        @(posedge clk); #1;
        check_output("done_clear", 32'(done), 32'd0);
        check_output("busy_fall", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check_output("write_total", 32'(write_count - wr0), 32'(n_write));
        check_output("done_total", 32'(done_count - dn0), 32'd1);
        check_output("queue_empty", 32'(exp_addr.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wr0;
        int dn0;
        reset_n           = 1'b0;
        start             = 1'b0;
        all               = 1'b0;
        lut_sel           = 2'd0;
        abort             = 1'b0;
        s_axis.s_tvalid_i = 1'b0;
        s_axis.s_tlast_i  = 1'b0;
        s_axis.s_tdata_i  = '0;
        #12;
        check_output("rst_coeff", coeff, 32'd0);
        check_output("rst_addr", 32'(coeff_addr), 32'd0);
        check_output("rst_en", 32'(coeff_en), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_short", 32'(err_short), 32'd0);
        check_output("rst_long", 32'(err_long), 32'd0);
        check_output("rst_tready", 32'(s_axis.s_tready_o), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] full table load");
        apply_stimulus(1'b1, 2'd0);
        send_frame(0, 64, 64, 1'b0, 32'h0001_0000, 1'b0, 1'b0);

        $display("[TB] single LUT 2");
        apply_stimulus(1'b0, 2'd2);
        send_frame(32, 16, 16, 1'b0, 32'h0002_0000, 1'b0, 1'b0);

        $display("[TB] short frame on LUT 1");
        apply_stimulus(1'b0, 2'd1);
        send_frame(16, 10, 10, 1'b0, 32'h0003_0000, 1'b1, 1'b0);

        $display("[TB] long frame on LUT 0");
        apply_stimulus(1'b0, 2'd0);
        send_frame(0, 20, 16, 1'b0, 32'h0004_0000, 1'b0, 1'b1);

        $display("[TB] full load with stream gaps");
        apply_stimulus(1'b1, 2'd0);
        send_frame(0, 64, 64, 1'b1, 32'h0007_0000, 1'b0, 1'b0);

        $display("[TB] abort after five beats");
        apply_stimulus(1'b1, 2'd0);
        wr0 = write_count;
        dn0 = done_count;
        for (int n = 0; n < 6; n++) begin
            s_axis.s_tvalid_i = 1'b1;
            s_axis.s_tdata_i  = 32'h0005_0000 + 32'(n);
            s_axis.s_tlast_i  = 1'b0;
            if (n == 2) begin
                start   = 1'b1;
                all     = 1'b0;
                lut_sel = 2'd3;
            end
            if (n == 5) begin
                abort = 1'b1;
            end else begin
                exp_addr.push_back(32'(n * 4));
                exp_data.push_back(32'h0005_0000 + 32'(n));
            end
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
        end
        s_axis.s_tvalid_i = 1'b0;
        check_output("abort_no_write", 32'(coeff_en), 32'd0);
        check_output("abort_idle", 32'(busy), 32'd0);
        check_output("abort_tready", 32'(s_axis.s_tready_o), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_output("abort_no_done", 32'(done_count - dn0), 32'd0);
        check_output("abort_writes", 32'(write_count - wr0), 32'd5);
        check_output("abort_queue", 32'(exp_addr.size()), 32'd0);
        check_output("abort_flags", 32'({err_short, err_long}), 32'd0);

        $display("[TB] reset mid-load");
        apply_stimulus(1'b1, 2'd0);
        wr0 = write_count;
        for (int n = 0; n < 3; n++) begin
            s_axis.s_tvalid_i = 1'b1;
            s_axis.s_tdata_i  = 32'h0006_0000 + 32'(n);
            exp_addr.push_back(32'(n * 4));
            exp_data.push_back(32'h0006_0000 + 32'(n));
            @(posedge clk); #1;
        end
        s_axis.s_tvalid_i = 1'b0;
        @(negedge clk); #1;
        check_output("pre_rst_coeff", coeff, 32'h0006_0002);
        reset_n = 1'b0;
        #1;
        check_output("arst_coeff", coeff, 32'd0);
        check_output("arst_addr", 32'(coeff_addr), 32'd0);
        check_output("arst_busy", 32'(busy), 32'd0);
        check_output("arst_tready", 32'(s_axis.s_tready_o), 32'd0);
        check_output("arst_en", 32'(coeff_en), 32'd0);
        check_output("arst_writes", 32'(write_count - wr0), 32'd3);
        @(posedge clk); #3;
        reset_n = 1'b1;
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
